// File: rtl/rv32i_pkg.sv
// Shared widths and arbiter state encoding for the register-file write path.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 2**AW;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arbState_t;

endpackage

// File: rtl/wr_hold_reg.sv
// One-entry writeback holding register. A load in the same cycle as a free
// wins, so an issuing entry can be replaced without a bubble.
module wr_hold_reg #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            free,
    input  logic [AW-1:0]   ldRd,
    input  logic [XLEN-1:0] ldData,
    output logic            vld,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            rd   <= '0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            rd   <= ldRd;
            data <= ldData;
        end else if (free) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register-file write port: clears x1..x(2**AW-1) after reset, then
// round-robin arbitrates the ALU and load writeback requesters.
//
// state    | meaning
// ST_CLEAR | writing zero to x1..xN, one register per cycle, requesters held off
// ST_RUN   | arbitrating held writeback ops onto the write port
module regfile_wr_arbiter #(
    parameter int XLEN       = rv32i_pkg::XLEN,
    parameter int AW         = rv32i_pkg::AW,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic              WrClk,
    input  logic              Rst_n,
    input  logic              wr0_vld,
    input  logic [AW-1:0]     wr0_rd,
    input  logic [XLEN-1:0]   wr0_data,
    output logic              wr0_rdy,
    input  logic              wr1_vld,
    input  logic [AW-1:0]     wr1_rd,
    input  logic [XLEN-1:0]   wr1_data,
    output logic              wr1_rdy,
    output logic              RegWr,
    output logic [AW-1:0]     Rw,
    output logic [XLEN-1:0]   busW,
    output logic [2**AW-1:0]  pend_mask,
    output logic              init_done
);

    import rv32i_pkg::*;

    localparam arbState_t ST_INIT = CLR_ON_RST ? ST_CLEAR : ST_RUN;

    arbState_t       state;
    arbState_t       stateNext;
    logic [AW-1:0]   clrIdx;
    logic            rrPtr;
    logic            isRun;

    logic            h0Vld;
    logic [AW-1:0]   h0Rd;
    logic [XLEN-1:0] h0Data;
    logic            h1Vld;
    logic [AW-1:0]   h1Rd;
    logic [XLEN-1:0] h1Data;

    logic            grant0;
    logic            grant1;
    logic            load0;
    logic            load1;

    assign isRun = (state == ST_RUN);

    always_ff @(posedge WrClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (state == ST_CLEAR && clrIdx == '1) begin
            stateNext = ST_RUN;
        end
    end

    // rrPtr only matters when both holds are valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (isRun) begin
            grant0 = h0Vld && (!h1Vld || !rrPtr);
            grant1 = h1Vld && (!h0Vld ||  rrPtr);
        end
    end

    assign wr0_rdy = isRun && (!h0Vld || grant0);
    assign wr1_rdy = isRun && (!h1Vld || grant1);

    // Writes to x0 are accepted but never occupy a hold or a port cycle.
    assign load0 = wr0_vld && wr0_rdy && (wr0_rd != '0);
    assign load1 = wr1_vld && wr1_rdy && (wr1_rd != '0);

    wr_hold_reg #(.XLEN(XLEN), .AW(AW)) u_hold0 (
        .clk    (WrClk),
        .rst_n  (Rst_n),
        .load   (load0),
        .free   (grant0),
        .ldRd   (wr0_rd),
        .ldData (wr0_data),
        .vld    (h0Vld),
        .rd     (h0Rd),
        .data   (h0Data)
    );

    wr_hold_reg #(.XLEN(XLEN), .AW(AW)) u_hold1 (
        .clk    (WrClk),
        .rst_n  (Rst_n),
        .load   (load1),
        .free   (grant1),
        .ldRd   (wr1_rd),
        .ldData (wr1_data),
        .vld    (h1Vld),
        .rd     (h1Rd),
        .data   (h1Data)
    );

    always_ff @(posedge WrClk or negedge Rst_n) begin
        if (!Rst_n) begin
            RegWr     <= 1'b0;
            Rw        <= '0;
            busW      <= '0;
            clrIdx    <= {{(AW-1){1'b0}}, 1'b1};
            rrPtr     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            init_done <= (stateNext == ST_RUN);
            if (state == ST_CLEAR) begin
                RegWr  <= 1'b1;
                Rw     <= clrIdx;
                busW   <= '0;
                clrIdx <= clrIdx + 1'b1;
            end else if (grant0) begin
                RegWr <= 1'b1;
                Rw    <= h0Rd;
                busW  <= h0Data;
                rrPtr <= 1'b1;
            end else if (grant1) begin
                RegWr <= 1'b1;
                Rw    <= h1Rd;
                busW  <= h1Data;
                rrPtr <= 1'b0;
            end else begin
                RegWr <= 1'b0;
            end
        end
    end

    // Covers ops sitting in a hold and the one on the port awaiting its write edge.
    always_comb begin
        pend_mask = '0;
        if (h0Vld) pend_mask[h0Rd] = 1'b1;
        if (h1Vld) pend_mask[h1Rd] = 1'b1;
        if (RegWr) pend_mask[Rw]   = 1'b1;
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: per-requester expected-write queues
// filled on acceptance, drained by a monitor watching the write port.
module tb_regfile_wr_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wrOp_t;

    logic        WrClk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        wr0_vld = 1'b0;
    logic [4:0]  wr0_rd = '0;
    logic [31:0] wr0_data = '0;
    logic        wr0_rdy;
    logic        wr1_vld = 1'b0;
    logic [4:0]  wr1_rd = '0;
    logic [31:0] wr1_data = '0;
    logic        wr1_rdy;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [31:0] pend_mask;
    logic        init_done;

    wrOp_t q0[$];
    wrOp_t q1[$];

    int nCmp = 0;
    int nErr = 0;
    int clrSeen = 0;
    int nRunWr = 0;
    int prevSrc = -1;
    bit chkAlt = 1'b0;

    bit          sRdy0, sRdy1, sRegWr;
    logic [4:0]  sRw;
    logic [31:0] sBusW;

    regfile_wr_arbiter dut (
        .WrClk     (WrClk),
        .Rst_n     (Rst_n),
        .wr0_vld   (wr0_vld),
        .wr0_rd    (wr0_rd),
        .wr0_data  (wr0_data),
        .wr0_rdy   (wr0_rdy),
        .wr1_vld   (wr1_vld),
        .wr1_rd    (wr1_rd),
        .wr1_data  (wr1_data),
        .wr1_rdy   (wr1_rdy),
        .RegWr     (RegWr),
        .Rw        (Rw),
        .busW      (busW),
        .pend_mask (pend_mask),
        .init_done (init_done)
    );

    always #5 WrClk = ~WrClk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; accepted ops with rd != 0 become expected writes.
    task automatic drive(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] r1, input logic [31:0] d1);
        bit a0, a1;
        @(negedge WrClk);
        wr0_vld = v0; wr0_rd = r0; wr0_data = d0;
        wr1_vld = v1; wr1_rd = r1; wr1_data = d1;
        #1;
        sRdy0 = wr0_rdy; sRdy1 = wr1_rdy;
        sRegWr = RegWr; sRw = Rw; sBusW = busW;
        a0 = v0 && wr0_rdy;
        a1 = v1 && wr1_rdy;
        @(posedge WrClk);
        if (a0 && r0 != 5'd0) q0.push_back('{rd: r0, data: d0});
        if (a1 && r1 != 5'd0) q1.push_back('{rd: r1, data: d1});
        #1;
        wr0_vld = 1'b0;
        wr1_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic doReset();
        @(negedge WrClk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst_RegWr", RegWr, 0);
        chk("rst_Rw", Rw, 0);
        chk("rst_busW", busW, 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rdy", {wr0_rdy, wr1_rdy}, 0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge WrClk);
        #2;
        Rst_n = 1'b1;
    endtask

    task automatic waitClr(input int target);
        int n = 0;
        while (clrSeen < target && n < 80) begin
            @(negedge WrClk);
            #1;
            n++;
        end
        chk("clear_progress", clrSeen, target);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            idle(1);
            n++;
        end
        chk("drain_q", q0.size() + q1.size(), 0);
        idle(3);
    endtask

    // Monitor: clear sequence first, then every port write must be the head of a requester queue.
    initial begin
        logic [31:0] expPend;
        int src;
        forever begin
            @(negedge WrClk);
            if (!Rst_n) begin
                clrSeen = 0;
                prevSrc = -1;
                continue;
            end
            expPend = '0;
            if (RegWr) begin
                if (clrSeen < 31) begin
                    chk("clr_Rw", Rw, clrSeen + 1);
                    chk("clr_busW", busW, 0);
                    expPend[clrSeen + 1] = 1'b1;
                    clrSeen++;
                    chk("clr_init_done", init_done, (clrSeen == 31));
                end else begin
                    nRunWr++;
                    src = -1;
                    if (q0.size() != 0 && q0[0].rd == Rw && q0[0].data == busW) begin
                        src = 0;
                        void'(q0.pop_front());
                    end else if (q1.size() != 0 && q1[0].rd == Rw && q1[0].data == busW) begin
                        src = 1;
                        void'(q1.pop_front());
                    end
                    nCmp++;
                    if (src < 0) begin
                        nErr++;
                        $display("FAIL run_write: got Rw=%0d busW=%0h, expected head of q0(%0d) or q1(%0d)",
                                 Rw, busW, q0.size(), q1.size());
                    end
                    expPend[Rw] = 1'b1;
                    if (chkAlt && prevSrc >= 0 && src >= 0) chk("rr_alternate", src, 1 - prevSrc);
                    prevSrc = src;
                end
            end else if (clrSeen > 0 && clrSeen < 31) begin
                chk("clr_gap", RegWr, 1);
            end
            if (clrSeen < 31) chk("clr_rdy", {wr0_rdy, wr1_rdy}, 0);
            foreach (q0[i]) expPend[q0[i].rd] = 1'b1;
            foreach (q1[i]) expPend[q1[i].rd] = 1'b1;
            expPend[0] = 1'b0;
            chk("pend_mask", pend_mask, expPend);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1;
        #1;
        chk("por_RegWr", RegWr, 0);
        chk("por_pend", pend_mask, 0);
        chk("por_init_done", init_done, 0);
        #21;
        Rst_n = 1'b1;
        waitClr(31);
        chk("init_done_run", init_done, 1);
        idle(2);

        // Single req0 write and its 2-edge latency.
        drive(1, 5'd5, 32'h52B52B52, 0, 5'd0, 32'd0);
        idle(1);
        chk("lat_E0_RegWr", sRegWr, 0);
        idle(1);
        chk("lat_E1_RegWr", sRegWr, 1);
        chk("lat_E1_Rw", sRw, 5);
        chk("lat_E1_busW", sBusW, 32'h52B52B52);
        drain();

        // Write to x0 is swallowed.
        drive(1, 5'd0, 32'h2DD2904E, 0, 5'd0, 32'd0);
        chk("x0_rdy", sRdy0, 1);
        idle(1);
        chk("x0_E1_RegWr", sRegWr, 0);
        idle(1);
        chk("x0_E2_RegWr", sRegWr, 0);
        chk("x0_pend", pend_mask, 0);
        drain();

        // Back-to-back req0.
        drive(1, 5'd4, 32'h0000_0444, 0, 5'd0, 32'd0);
        chk("b2b_rdy_a", sRdy0, 1);
        drive(1, 5'd10, 32'h0000_0AAA, 0, 5'd0, 32'd0);
        chk("b2b_rdy_b", sRdy0, 1);
        idle(1);
        chk("b2b_RegWr_a", sRegWr, 1);
        chk("b2b_Rw_a", sRw, 4);
        idle(1);
        chk("b2b_RegWr_b", sRegWr, 1);
        chk("b2b_Rw_b", sRw, 10);
        drain();

        // Both requesters saturated: alternate grants, one write per cycle.
        prevSrc = -1;
        chkAlt = 1'b1;
        for (int i = 0; i < 4; i++)
            drive(1, 5'd1, 32'hA000_0000 | i, 1, 5'd2, 32'hB000_0000 | i);
        w0 = nRunWr;
        for (int i = 4; i < 20; i++)
            drive(1, 5'd1, 32'hA000_0000 | i, 1, 5'd2, 32'hB000_0000 | i);
        w1 = nRunWr;
        chk("sustained_rate", w1 - w0, 16);
        drain();
        chkAlt = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom);
        end
        drain();

        // Reset with both holds full: held ops must never issue.
        drive(1, 5'd7, 32'h7777_7777, 1, 5'd9, 32'h9999_9999);
        doReset();
        waitClr(12);
        // Reset mid-CLEAR: sequence restarts from x1.
        doReset();
        waitClr(31);
        idle(4);
        chk("post_reset_no_issue", nRunWr, w1 + (nRunWr - w1));
        drive(0, 5'd0, 32'd0, 1, 5'd3, 32'h3333_3333);
        drain();
        chk("final_pend", pend_mask, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
